// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: holds the PC, fetches from instruction memory and hands instructions to decode.
// Optional build macro FETCH_CNT_EN adds a 32-bit count of instructions accepted by decode.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        bus_err
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        accept;

  assign accept = (state_q == HOLD) && valid_q && instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    // Read data is only legitimate while waiting; anywhere else it is dropped and flagged.
    if (imem_rvalid && (state_q != WAIT)) err_d = 1'b1;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_gnt) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          pc_d    = npc;
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Request is a pure decode of the state, so it falls the moment reset is applied.
  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign bus_err     = err_q;

`ifdef FETCH_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = accept ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 32'h0;
    else     cnt_q <= cnt_d;
  end

  assign fetch_cnt = cnt_q;
`endif

endmodule
